// File: rtl/tail_light_pkg.sv
// Shared mode encodings and the chase-mask helper for the tail-light sequencer.
package tail_light_pkg;

    typedef logic [2:0] modeT;

    localparam modeT IDLE       = 3'b000;
    localparam modeT HAZARDS    = 3'b001;
    localparam modeT TURN_LEFT  = 3'b010;
    localparam modeT TURN_RIGHT = 3'b011;

    localparam int MAX_LAMPS = 32;

    // Lamps 0..step lit while step < n; step == n is the blank frame.
    function automatic logic [MAX_LAMPS-1:0] thermo(input int step, input int n);
        logic [MAX_LAMPS-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_LAMPS; i++) begin
            if (i < n && i <= step && step < n) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/tail_light_tick_gen.sv
// Animation prescaler: one-cycle tick every TICK_DIV clocks while enabled.
module tail_light_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || !en) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = en && (count == LAST_COUNT);

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light controller: synchronised inputs, registered mode FSM, chase/blink
// step counter and registered lamp drive with brake overlay.
module tail_light_sequencer
    import tail_light_pkg::*;
#(
    parameter int LAMPS_PER_SIDE = 3,
    parameter int TICK_DIV       = 12500000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                SW,
    input  logic                      turn_side_r,
    input  logic                      brake,
    output logic [LAMPS_PER_SIDE-1:0] left_lamps,
    output logic [LAMPS_PER_SIDE-1:0] right_lamps,
    output logic [2:0]                state
);

    localparam int STEP_W = $clog2(LAMPS_PER_SIDE + 1);
    localparam logic [STEP_W-1:0] LAST_TURN_STEP = STEP_W'(LAMPS_PER_SIDE);
    localparam logic [LAMPS_PER_SIDE-1:0] ALL_ON = {LAMPS_PER_SIDE{1'b1}};

    logic [1:0]                swMeta, swSync;
    logic                      turnSideMeta, turnSideSync;
    logic                      brakeMeta, brakeSync;
    modeT                      request;
    logic                      modeChange;
    logic                      tick;
    logic [STEP_W-1:0]         step;
    logic [LAMPS_PER_SIDE-1:0] chase;
    logic [LAMPS_PER_SIDE-1:0] leftNext, rightNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swMeta       <= '0;
            swSync       <= '0;
            turnSideMeta <= 1'b0;
            turnSideSync <= 1'b0;
            brakeMeta    <= 1'b0;
            brakeSync    <= 1'b0;
        end else begin
            swMeta       <= SW;
            swSync       <= swMeta;
            turnSideMeta <= turn_side_r;
            turnSideSync <= turnSideMeta;
            brakeMeta    <= brake;
            brakeSync    <= brakeMeta;
        end
    end

    // Hazards outrank a turn request; a side flip is just a different request.
    always_comb begin
        request = IDLE;
        if (swSync[0]) begin
            request = HAZARDS;
        end else if (swSync[1]) begin
            request = turnSideSync ? TURN_RIGHT : TURN_LEFT;
        end
    end

    assign modeChange = (request != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= request;
        end
    end

    tail_light_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) tickGen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (modeChange),
        .en   (state != IDLE),
        .tick (tick)
    );

    // A mode change takes precedence over a coincident tick so the new pattern starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
        end else if (modeChange) begin
            step <= '0;
        end else if (tick) begin
            case (state)
                HAZARDS:               step <= (step == '0) ? STEP_W'(1) : '0;
                TURN_LEFT, TURN_RIGHT: step <= (step == LAST_TURN_STEP) ? '0 : step + STEP_W'(1);
                default:               step <= '0;
            endcase
        end else if (state == IDLE) begin
            step <= '0;
        end
    end

    assign chase = LAMPS_PER_SIDE'(thermo(int'(step), LAMPS_PER_SIDE));

    always_comb begin
        leftNext  = '0;
        rightNext = '0;
        case (state)
            HAZARDS: begin
                if (step == '0) begin
                    leftNext  = ALL_ON;
                    rightNext = ALL_ON;
                end
            end
            TURN_LEFT: begin
                leftNext  = chase;
                rightNext = brakeSync ? ALL_ON : '0;
            end
            TURN_RIGHT: begin
                rightNext = chase;
                leftNext  = brakeSync ? ALL_ON : '0;
            end
            default: begin
                leftNext  = brakeSync ? ALL_ON : '0;
                rightNext = brakeSync ? ALL_ON : '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_lamps  <= '0;
            right_lamps <= '0;
        end else begin
            left_lamps  <= leftNext;
            right_lamps <= rightNext;
        end
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench for tail_light_sequencer with 3 lamps per side and a 4-clock tick.
module tb_tail_light_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw;
    logic       turnSide;
    logic       brake;
    logic [2:0] leftLamps;
    logic [2:0] rightLamps;
    logic [2:0] state;

    int checkCount = 0;
    int errorCount = 0;

    tail_light_sequencer #(
        .LAMPS_PER_SIDE(3),
        .TICK_DIV      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SW         (sw),
        .turn_side_r(turnSide),
        .brake      (brake),
        .left_lamps (leftLamps),
        .right_lamps(rightLamps),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkLamps(input string tag, input logic [2:0] expLeft, input logic [2:0] expRight);
        checkOutput({tag, "/left"},  {5'b0, leftLamps},  {5'b0, expLeft});
        checkOutput({tag, "/right"}, {5'b0, rightLamps}, {5'b0, expRight});
    endtask

    task automatic checkState(input string tag, input logic [2:0] expState);
        checkOutput({tag, "/state"}, {5'b0, state}, {5'b0, expState});
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic stepClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] newSw, input logic newSide, input logic newBrake);
        sw       = newSw;
        turnSide = newSide;
        brake    = newBrake;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0);
        stepClk(2);
        checkState("reset", 3'b000);
        checkLamps("reset", 3'b000, 3'b000);

        // Hazards running, then reset dropped mid-pattern.
        rst_n = 1'b1;
        applyStimulus(2'b01, 1'b0, 1'b0);
        stepClk(4);
        checkLamps("hazRun", 3'b111, 3'b111);
        rst_n = 1'b0;
        #2;
        checkState("asyncRst", 3'b000);
        checkLamps("asyncRst", 3'b000, 3'b000);
        stepClk(1);
        rst_n = 1'b1;
        stepClk(2);
        checkState("relE2", 3'b000);
        stepClk(1);
        checkState("relE3", 3'b001);
        checkLamps("relE3", 3'b000, 3'b000);
        stepClk(1);
        checkLamps("hazOn", 3'b111, 3'b111);
        stepClk(3);
        checkLamps("hazOnEnd", 3'b111, 3'b111);
        stepClk(1);
        checkLamps("hazOff", 3'b000, 3'b000);
        stepClk(4);
        checkLamps("hazOn2", 3'b111, 3'b111);

        // Left turn requested mid-count: frame lengths must still be 4 clocks.
        stepClk(1);
        applyStimulus(2'b10, 1'b0, 1'b0);
        stepClk(3);
        checkState("left", 3'b010);
        stepClk(1);
        checkLamps("leftS0", 3'b001, 3'b000);
        stepClk(3);
        checkLamps("leftS0End", 3'b001, 3'b000);
        stepClk(1);
        checkLamps("leftS1", 3'b011, 3'b000);
        stepClk(4);
        checkLamps("leftS2", 3'b111, 3'b000);
        stepClk(4);
        checkLamps("leftS3", 3'b000, 3'b000);
        stepClk(4);
        checkLamps("leftWrap", 3'b001, 3'b000);
        stepClk(8);
        checkLamps("leftS2b", 3'b111, 3'b000);

        // Side flip at step 2; the new mode lands on the same edge as a tick.
        applyStimulus(2'b10, 1'b1, 1'b0);
        stepClk(3);
        checkState("flip", 3'b011);
        stepClk(1);
        checkLamps("rightS0", 3'b000, 3'b001);
        stepClk(3);
        checkLamps("rightS0End", 3'b000, 3'b001);
        stepClk(1);
        checkLamps("rightS1", 3'b000, 3'b011);

        // Brake during a right turn lights the left side only.
        applyStimulus(2'b10, 1'b1, 1'b1);
        stepClk(3);
        checkLamps("brakeTurn", 3'b111, 3'b011);
        stepClk(1);
        checkLamps("brakeTurnS2", 3'b111, 3'b111);
        stepClk(4);
        checkLamps("brakeTurnS3", 3'b111, 3'b000);

        // Brake in IDLE lights both sides; releasing it blanks them.
        applyStimulus(2'b00, 1'b1, 1'b1);
        stepClk(3);
        checkState("idle", 3'b000);
        stepClk(1);
        checkLamps("brakeIdle", 3'b111, 3'b111);
        applyStimulus(2'b00, 1'b1, 1'b0);
        stepClk(3);
        checkLamps("idleOff", 3'b000, 3'b000);

        // Hazard request outranks a simultaneous turn request.
        applyStimulus(2'b11, 1'b1, 1'b0);
        stepClk(3);
        checkState("hazPrio", 3'b001);
        stepClk(1);
        checkLamps("hazPrioOn", 3'b111, 3'b111);
        stepClk(4);
        checkLamps("hazPrioOff", 3'b000, 3'b000);

        // New mode lands exactly on a tick edge: first frame must be step 0 for 4 clocks.
        applyStimulus(2'b10, 1'b0, 1'b0);
        stepClk(3);
        checkState("tickEdge", 3'b010);
        stepClk(1);
        checkLamps("tickEdgeS0", 3'b001, 3'b000);
        stepClk(3);
        checkLamps("tickEdgeS0End", 3'b001, 3'b000);
        stepClk(1);
        checkLamps("tickEdgeS1", 3'b011, 3'b000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
